mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single CPU-side data port of the memory map (address, write data, memop, write enable, read data) between two masters.
- Master 0 is the CPU load/store unit. Master 1 is a DMA engine, e.g. a VGA scroll/clear copier.
- Fixed priority to master 0, with bounded locked bursts and a starvation guard for master 1.
- Sits between the CPU/DMA and the memory map. The memory map read data arrives one cycle after the address (synchronous RAM).

Parameters:
- MAX_BURST, 8: maximum consecutive granted beats under lock before a forced release (>=1).
- STARVE_LIMIT, 4: consecutive denied cycles of m1 before m1 takes priority (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req, m1_req  input  1 each  master requests a beat this cycle.
- m0_lock, m1_lock  input  1 each  more beats follow; keep ownership.
- m0_addr, m1_addr  input  32 each  byte address.
- m0_wrdata, m1_wrdata  input  32 each  write data.
- m0_memop, m1_memop  input  3 each  memop code, passed through unchanged.
- m0_we, m1_we  input  1 each  write enable.
- m0_gnt, m1_gnt  output  1 each  beat accepted this cycle (combinational).
- m0_rdvalid, m1_rdvalid  output  1 each  bus_rddata belongs to this master's read beat from the previous cycle.
- rddata  output  32  bus_rddata passed through to both masters.
- bus_addr  output  32  address to the memory map.
- bus_wrdata  output  32  write data to the memory map.
- bus_memop  output  3  memop to the memory map.
- bus_we  output  1  write enable to the memory map.
- bus_rddata  input  32  read data from the memory map.
- perf_gnt0, perf_gnt1, perf_stall0, perf_stall1  output  32 each  performance counters (see Optional Feature).

Behaviour:
- Arbitration FSM states:
  - IDLE: no owner.
  - OWN0: m0 holds a lock.
  - OWN1: m1 holds a lock.
- Registered state: fsm, burst_cnt (counts 0..MAX_BURST), starve_cnt (counts 0..STARVE_LIMIT, saturating), prio1 flag, rdvalid registers.
- Reset (asynchronous, rst_n=0): fsm=IDLE, burst_cnt=0, starve_cnt=0, prio1=0, m0_rdvalid=m1_rdvalid=0.
  - Grants are combinational and held low while in reset.
  - Perf counters are 0.
  - A beat in flight is dropped; its rdvalid never asserts.
- Grant in IDLE:
  - m1 wins if m1_req and (starve_cnt==STARVE_LIMIT or prio1).
  - Otherwise m0 wins if m0_req; otherwise m1 wins if m1_req.
- Grant in OWNx: only x can be granted, and only when x_req=1. The other master is denied.
- At most one grant per cycle.
- Bus mux:
  - The granted master drives bus_addr/wrdata/memop/we.
  - With no grant, bus_we=0 and the other bus outputs carry m0's inputs.
  - A write commits in its grant cycle.
- Read latency: x_rdvalid is registered from (x_gnt & ~x_we) and is high exactly one cycle after the grant. rddata=bus_rddata always.
- Transitions:
  - IDLE -> OWNx when x is granted with x_lock=1 and MAX_BURST>1; burst_cnt<=1.
  - OWNx, granted beat with x_lock=1: burst_cnt increments.
  - OWNx -> IDLE on any of:
    - a granted beat with x_lock=0;
    - a cycle with x_req=0;
    - burst_cnt reaching MAX_BURST on a granted beat (forced release).
  - burst_cnt is cleared in IDLE.
- Forced release:
  - Of OWN0: set prio1=1.
  - Of OWN1: clear prio1.
  - prio1 also clears whenever m1 is granted.
- Starvation counter:
  - starve_cnt increments on a cycle with m1_req & ~m1_gnt, saturating at STARVE_LIMIT.
  - It is cleared on m1_gnt.
  - It holds when m1_req=0.
- Simultaneous req in IDLE with no starvation and no prio1: m0 granted, m1 denied, starve_cnt+1.
- Requesters must hold addr/data/memop/we stable until granted. The arbiter does not check this.
- Worst-case m1 wait: STARVE_LIMIT + MAX_BURST cycles.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_gnt0/1 count grants per master.
  - perf_stall0/1 count cycles with x_req & ~x_gnt.
  - All four are 32-bit, wrap modulo 2^32 and clear on reset.
- Undefined: all four perf outputs are tied to 0 and no counter flops are built. Arbitration behaviour is identical either way.

Test Plan:
- Single master: m0 reads addr 0x00100004 alone -> m0_gnt same cycle, bus_addr=0x00100004, m0_rdvalid high the next cycle with rddata=bus_rddata, m1_rdvalid=0.
- Contention: both request continuously without lock, STARVE_LIMIT=4 -> grants m0,m0,m0,m0,m1,m0,m0,m0,m0,m1... and starve_cnt returns to 0 after each m1 grant.
- Locked burst: m1 takes IDLE with lock for 3 beats while m0 requests -> m1 granted 3 consecutive cycles, m0 denied, FSM back to IDLE, m0 granted next.
- Forced release: m0 locks continuously with MAX_BURST=8 while m1 requests -> 8 m0 grants, then m1 granted via prio1 in cycle 9, then m0 regains.
- Write path: m1 write, we=1, data 0xDEADBEEF, memop=2 to 0x00300010 -> bus_we=1 only in the grant cycle with matching fields; no rdvalid.
- Reset mid-burst: rst_n low during OWN1 beat 2 -> grants drop immediately, rdvalid=0 the next cycle; after release FSM=IDLE and m0 wins a simultaneous request; with ARB_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : two-master arbiter for the memory-map CPU data port (m0 = LSU, m1 = DMA).
// Latency : grants and bus mux are combinational; read-valid is flagged one cycle after the grant.
// Backpr. : a denied master sees x_gnt=0 and must hold its request fields until it is granted.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   mX_req/lock/addr/wrdata/memop/we   per-master beat request (X = 0,1)
//   mX_gnt                     beat accepted this cycle
//   mX_rdvalid                 rddata belongs to this master's read beat of the previous cycle
//   rddata                     bus_rddata passed through to both masters
//   bus_*                      memory-map side of the shared port
//   perf_gnt0/1, perf_stall0/1 performance counters, built only when ARB_PERF_CNT_EN is defined
//
// Build option: define ARB_PERF_CNT_EN to build the 32-bit performance counters;
// otherwise the perf outputs are tied to 0 and no counter flops exist.
module mem_port_arbiter #(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wrdata,
  input  logic [31:0] m1_wrdata,
  input  logic [2:0]  m0_memop,
  input  logic [2:0]  m1_memop,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rdvalid,
  output logic        m1_rdvalid,
  output logic [31:0] rddata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic [2:0]  bus_memop,
  output logic        bus_we,
  input  logic [31:0] bus_rddata,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_stall0,
  output logic [31:0] perf_stall1
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // A single-beat burst limit means a lock can never be held past its first beat.
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic [SW-1:0] starve_q, starve_d;
  logic          prio1_q, prio1_d;
  logic          gnt0_raw, gnt1_raw;

  // Grant selection
  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_req && (starve_q == STARVE_MAX || prio1_q)) gnt1_raw = 1'b1;
        else if (m0_req)                                     gnt0_raw = 1'b1;
        else if (m1_req)                                     gnt1_raw = 1'b1;
      end
      OWN0:    gnt0_raw = m0_req;
      OWN1:    gnt1_raw = m1_req;
      default: ;
    endcase
  end

  // Grants are forced low while reset is asserted, independent of state.
  assign m0_gnt = gnt0_raw & rst_n;
  assign m1_gnt = gnt1_raw & rst_n;

  // Bus mux: m0's fields are the idle default; only the write enable is gated.
  assign bus_addr   = m1_gnt ? m1_addr   : m0_addr;
  assign bus_wrdata = m1_gnt ? m1_wrdata : m0_wrdata;
  assign bus_memop  = m1_gnt ? m1_memop  : m0_memop;
  assign bus_we     = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign rddata     = bus_rddata;

  assign burst_inc = burst_q + BW'(1);

  // Next-state: ownership, burst length, priority flag, starvation counter
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    prio1_d  = prio1_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (CAN_LOCK && gnt0_raw && m0_lock) begin
          state_d = OWN0;
          burst_d = BW'(1);
        end else if (CAN_LOCK && gnt1_raw && m1_lock) begin
          state_d = OWN1;
          burst_d = BW'(1);
        end
      end
      OWN0: begin
        if (!m0_req || !m0_lock) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (burst_inc == BURST_MAX) begin
          // Forced release: hand the next idle cycle to m1.
          state_d = IDLE;
          burst_d = '0;
          prio1_d = 1'b1;
        end else begin
          burst_d = burst_inc;
        end
      end
      OWN1: begin
        if (!m1_req || !m1_lock) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (burst_inc == BURST_MAX) begin
          state_d = IDLE;
          burst_d = '0;
          prio1_d = 1'b0;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase

    if (gnt1_raw) prio1_d = 1'b0;

    if (gnt1_raw)                              starve_d = '0;
    else if (m1_req && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      starve_q   <= '0;
      prio1_q    <= 1'b0;
      m0_rdvalid <= 1'b0;
      m1_rdvalid <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      starve_q   <= starve_d;
      prio1_q    <= prio1_d;
      m0_rdvalid <= gnt0_raw & ~m0_we;
      m1_rdvalid <= gnt1_raw & ~m1_we;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_stall0_q, perf_stall1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt0_q   <= '0;
      perf_gnt1_q   <= '0;
      perf_stall0_q <= '0;
      perf_stall1_q <= '0;
    end else begin
      if (gnt0_raw)             perf_gnt0_q   <= perf_gnt0_q + 32'd1;
      if (gnt1_raw)             perf_gnt1_q   <= perf_gnt1_q + 32'd1;
      if (m0_req && !gnt0_raw)  perf_stall0_q <= perf_stall0_q + 32'd1;
      if (m1_req && !gnt1_raw)  perf_stall1_q <= perf_stall1_q + 32'd1;
    end
  end

  assign perf_gnt0   = perf_gnt0_q;
  assign perf_gnt1   = perf_gnt1_q;
  assign perf_stall0 = perf_stall0_q;
  assign perf_stall1 = perf_stall1_q;
`else
  assign perf_gnt0   = '0;
  assign perf_gnt1   = '0;
  assign perf_stall0 = '0;
  assign perf_stall1 = '0;
`endif

endmodule
